// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game-flow controller and its timer.
package simon_pkg;

  localparam int unsigned COUNT_W = 5;

  localparam logic BIT_A = 1'b0;
  localparam logic BIT_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    ROUND_GAP,
    WIN,
    LOSE
  } state_t;

  // Largest of three cycle counts; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/simon_timer.sv
// Down-counting interval timer: a load of N produces a one-cycle expired
// pulse exactly N cycles later. A load of 0 never expires.
module simon_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count register: load has priority, otherwise decrement down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // The last counted cycle is the expiry cycle.
  always_comb begin
    expired = (count == WIDTH'(1));
  end

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon game-flow controller: plays back the sequence on two LEDs, checks
// button presses against it, and drives the round/position counter pulses.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS     = 16,
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               btn_a,
  input  logic               btn_b,
  input  logic               expected_bit,
  input  logic [COUNT_W-1:0] round_count,
  input  logic [COUNT_W-1:0] pos_count,
  output logic               round_inc,
  output logic               round_rst,
  output logic               pos_inc,
  output logic               pos_rst,
  output logic               led_a,
  output logic               led_b,
  output logic               win,
  output logic               lose
);

  localparam int unsigned TIMER_W =
    $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) + 1;

  localparam logic [TIMER_W-1:0] SHOW_LD    = TIMER_W'(SHOW_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LD     = TIMER_W'(GAP_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_LD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [COUNT_W-1:0] MAX_R      = COUNT_W'(MAX_ROUNDS);
  localparam logic               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t               state, state_n;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_value;
  logic                 tmr_expired;

  logic                 round_inc_n, round_rst_n, pos_inc_n, pos_rst_n;
  logic                 led_a_n, led_b_n, win_n, lose_n;
  logic                 press_any, press_both, press_bit;

  simon_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .expired   (tmr_expired)
  );

  // Decode the press into the bit it stands for.
  always_comb begin
    press_any  = btn_a | btn_b;
    press_both = btn_a & btn_b;
    press_bit  = btn_b ? BIT_B : BIT_A;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, timer loads and counter pulse requests.
  always_comb begin
    state_n     = state;
    tmr_load    = 1'b0;
    tmr_value   = SHOW_LD;
    round_inc_n = 1'b0;
    round_rst_n = 1'b0;
    pos_inc_n   = 1'b0;
    pos_rst_n   = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          round_rst_n = 1'b1;
          pos_rst_n   = 1'b1;
          tmr_load    = 1'b1;
          tmr_value   = SHOW_LD;
          state_n     = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = GAP_LD;
          state_n   = SHOW_OFF;
        end
      end
      SHOW_OFF: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (pos_count == round_count) begin
            pos_rst_n = 1'b1;
            tmr_value = TIMEOUT_LD;
            state_n   = WAIT_IN;
          end else begin
            pos_inc_n = 1'b1;
            tmr_value = SHOW_LD;
            state_n   = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        if (press_both) begin
          state_n = LOSE;
        end else if (press_any) begin
          if (press_bit != expected_bit) begin
            state_n = LOSE;
          end else if (pos_count < round_count) begin
            pos_inc_n = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = TIMEOUT_LD;
          end else if ((pos_count == round_count) && (round_count == MAX_R)) begin
            state_n = WIN;
          end else begin
            round_inc_n = 1'b1;
            pos_rst_n   = 1'b1;
            tmr_load    = 1'b1;
            tmr_value   = GAP_LD;
            state_n     = ROUND_GAP;
          end
        end else if (TIMEOUT_EN && tmr_expired) begin
          state_n = LOSE;
        end
      end
      ROUND_GAP: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = SHOW_LD;
          state_n   = SHOW_ON;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // LED and result levels. LEDs follow the current state one cycle late so
  // that expected_bit has already settled after the counter pulse that
  // preceded this playback step; the lit time is still SHOW_CYCLES.
  always_comb begin
    led_a_n = (state == SHOW_ON) && (expected_bit == BIT_A);
    led_b_n = (state == SHOW_ON) && (expected_bit == BIT_B);
    win_n   = (state_n == WIN);
    lose_n  = (state_n == LOSE);
  end

  // Output register; reset clears every output, so no pulse leaves in the
  // reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_inc <= 1'b0;
      round_rst <= 1'b0;
      pos_inc   <= 1'b0;
      pos_rst   <= 1'b0;
      led_a     <= 1'b0;
      led_b     <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      round_inc <= round_inc_n;
      round_rst <= round_rst_n;
      pos_inc   <= pos_inc_n;
      pos_rst   <= pos_rst_n;
      led_a     <= led_a_n;
      led_b     <= led_b_n;
      win       <= win_n;
      lose      <= lose_n;
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Testbench for simon_round_ctrl: models the two counters and the sequence
// store, drives cycle-by-cycle vectors and checks every output each cycle.
module tb_simon_round_ctrl;

  localparam logic [7:0] O_RI = 8'h80;
  localparam logic [7:0] O_RR = 8'h40;
  localparam logic [7:0] O_PI = 8'h20;
  localparam logic [7:0] O_PR = 8'h10;
  localparam logic [7:0] O_LA = 8'h08;
  localparam logic [7:0] O_LB = 8'h04;
  localparam logic [7:0] O_W  = 8'h02;
  localparam logic [7:0] O_L  = 8'h01;

  logic       clk = 1'b0;
  logic       reset, start, btn_a, btn_b;
  logic       expected_bit;
  logic [4:0] round_count, pos_count;
  logic       round_inc, round_rst, pos_inc, pos_rst;
  logic       led_a, led_b, win, lose;

  // Sequence store: position 1 = 1, position 2 = 0, rest alternating.
  logic [31:0] seq = 32'hAAAA_AAA9;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic        s;
    logic        a;
    logic        b;
    logic [7:0]  exp;
    int unsigned rep;
    string       name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  simon_round_ctrl #(
    .MAX_ROUNDS    (2),
    .SHOW_CYCLES   (3),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn_a       (btn_a),
    .btn_b       (btn_b),
    .expected_bit(expected_bit),
    .round_count (round_count),
    .pos_count   (pos_count),
    .round_inc   (round_inc),
    .round_rst   (round_rst),
    .pos_inc     (pos_inc),
    .pos_rst     (pos_rst),
    .led_a       (led_a),
    .led_b       (led_b),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  // Counter models: sample the pulses on the falling edge.
  initial begin
    round_count = 5'd1;
    pos_count   = 5'd1;
    forever begin
      @(negedge clk);
      if (round_rst)      round_count = 5'd1;
      else if (round_inc) round_count = round_count + 5'd1;
      if (pos_rst)        pos_count = 5'd1;
      else if (pos_inc)   pos_count = pos_count + 5'd1;
    end
  end

  always_comb expected_bit = seq[pos_count - 5'd1];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic add(input logic s, input logic a, input logic b,
                     input logic [7:0] exp, input int unsigned rep,
                     input string name);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.exp = exp; v.rep = rep; v.name = name;
    vecs.push_back(v);
  endtask

  // One cycle: drive inputs, queue the expected outputs, compare after edge.
  task automatic apply(input logic s, input logic a, input logic b,
                       input logic r, input logic [7:0] exp,
                       input string name);
    logic [7:0] got, want;
    start = s; btn_a = a; btn_b = b; reset = r;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0; btn_a = 1'b0; btn_b = 1'b0; reset = 1'b0;
    got  = {round_inc, round_rst, pos_inc, pos_rst, led_a, led_b, win, lose};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: outputs {ri,rr,pi,pr,la,lb,w,l}=%b expected %b",
               name, cyc, got, want);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      for (int unsigned r = 0; r < vecs[i].rep; r++) begin
        apply(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp, vecs[i].name);
      end
    end
    vecs.delete();
  endtask

  task automatic check_cnt(input logic [4:0] want_r, input logic [4:0] want_p,
                           input string name);
    n_checks++;
    if (round_count !== want_r || pos_count !== want_p) begin
      n_fail++;
      $display("FAIL %s: round/pos counts %0d/%0d expected %0d/%0d",
               name, round_count, pos_count, want_r, want_p);
    end
  endtask

  initial begin
    start = 1'b0; btn_a = 1'b0; btn_b = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, first playback, round 1 pass, round 2 playback, loss.
    add(0, 0, 0, 8'h00,       2, "reset_idle");
    add(1, 0, 0, O_RR | O_PR, 1, "start_pulses");
    add(0, 0, 0, O_LB,        3, "r1_show_b");
    add(0, 0, 0, 8'h00,       1, "r1_gap");
    add(0, 0, 0, O_PR,        1, "r1_enter_wait");
    add(0, 0, 1, O_RI | O_PR, 1, "r1_press_b");
    add(0, 0, 0, 8'h00,       2, "round_gap");
    add(0, 0, 0, O_LB,        3, "r2_show1_b");
    add(0, 0, 0, 8'h00,       1, "r2_gap1");
    add(0, 0, 0, O_PI,        1, "r2_pos_inc");
    add(0, 0, 0, O_LA,        3, "r2_show2_a");
    add(0, 0, 0, 8'h00,       1, "r2_gap2");
    add(0, 0, 0, O_PR,        1, "r2_enter_wait");
    add(0, 1, 0, O_L,         1, "wrong_press_lose");
    add(0, 0, 1, O_L,         1, "lose_sticky_btn");
    add(0, 0, 0, O_L,         1, "lose_sticky");
    // Restart from LOSE, full correct game to WIN.
    add(1, 0, 0, O_RR | O_PR, 1, "restart_from_lose");
    add(1, 0, 0, O_LB,        1, "start_ignored_show");
    add(0, 0, 0, O_LB,        2, "g2_r1_show");
    add(0, 1, 0, 8'h00,       1, "press_ignored_gap");
    add(0, 0, 0, O_PR,        1, "g2_r1_wait");
    add(0, 0, 1, O_RI | O_PR, 1, "g2_r1_press");
    add(0, 0, 1, 8'h00,       1, "press_ignored_rgap");
    add(0, 0, 0, 8'h00,       1, "g2_round_gap");
    add(0, 0, 0, O_LB,        3, "g2_r2_show1");
    add(0, 0, 0, 8'h00,       1, "g2_r2_gap1");
    add(0, 0, 0, O_PI,        1, "g2_r2_pos_inc");
    add(0, 0, 0, O_LA,        3, "g2_r2_show2");
    add(0, 0, 0, 8'h00,       1, "g2_r2_gap2");
    add(0, 0, 0, O_PR,        1, "g2_r2_wait");
    add(0, 0, 1, O_PI,        1, "g2_r2_press1");
    add(0, 1, 0, O_W,         1, "final_press_win");
    add(0, 1, 0, O_W,         1, "win_sticky_btn");
    add(0, 0, 0, O_W,         1, "win_sticky");
    run_table();
    check_cnt(5'd2, 5'd2, "counts_at_win");

    // Restart from WIN, both buttons at once loses.
    add(1, 0, 0, O_RR | O_PR, 1, "restart_from_win");
    add(0, 0, 0, O_LB,        3, "g3_show");
    add(0, 0, 0, 8'h00,       1, "g3_gap");
    add(0, 0, 0, O_PR,        1, "g3_wait");
    add(0, 1, 1, O_L,         1, "both_buttons_lose");
    add(0, 0, 0, O_L,         1, "both_lose_sticky");
    run_table();
    check_cnt(5'd1, 5'd1, "counts_after_both");

    // Timeout: lose rises 5 cycles after WAIT_IN is entered.
    apply(1, 0, 0, 0, O_RR | O_PR, "to_start");
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, O_LB, "to_show");
    apply(0, 0, 0, 0, 8'h00, "to_gap");
    apply(0, 0, 0, 0, O_PR,  "to_enter_wait");
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 8'h00, "to_waiting");
    apply(0, 0, 0, 0, O_L, "timeout_lose");
    apply(0, 0, 0, 0, O_L, "timeout_sticky");

    // Reset in the middle of SHOW_ON.
    apply(1, 0, 0, 0, O_RR | O_PR, "rs_start");
    apply(0, 0, 0, 0, O_LB, "rs_show");
    apply(0, 0, 0, 1, 8'h00, "reset_mid_show");
    apply(0, 0, 0, 0, 8'h00, "after_reset_idle");
    apply(0, 1, 0, 0, 8'h00, "after_reset_press_ignored");
    apply(1, 0, 0, 0, O_RR | O_PR, "start_after_reset");
    apply(0, 0, 0, 0, O_LB, "show_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
